i2c_dri: RTL and testbench

Byte-level I2C/SCCB master that executes one register transaction per `i2c_exec` pulse. It is the bus-side responder to the camera register-configuration sequencer. It takes a slave register address, write data and a read/write flag, and drives SCL/SDA. It returns `i2c_done`, the read byte and an acknowledge-error flag. It sits between the OV5640 configuration sequencer and the sensor pins.

---
 rtl/i2c_pkg.sv | 12 +
 rtl/i2c_qtick.sv | 28 ++
 rtl/i2c_dri.sv | 108 ++++++++++
 tb/tb_i2c_dri.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM states, bit-framing constants and quarter-tick divider helper
package i2c_pkg;
    typedef enum logic [3:0] {
        ST_IDLE, ST_START, ST_SLADDR_W, ST_ADDR_H, ST_ADDR_L,
        ST_DATA_WR, ST_RESTART, ST_SLADDR_R, ST_DATA_RD, ST_STOP
    } state_t;
    localparam int BYTE_BITS = 9;
    localparam int QTR = 4;
    function automatic int calc_div4(input int clk_freq, input int i2c_freq);
        return clk_freq / (QTR * i2c_freq);
    endfunction
endpackage

// File: rtl/i2c_qtick.sv
// i2c_qtick: quarter-bit tick generator, held cleared while disabled
module i2c_qtick
    import i2c_pkg::*;
#(
    parameter int DIV4 = 50
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   tick,
    output logic [$clog2(QTR)-1:0] qtr
);
    localparam int CW = $clog2(DIV4) > 0 ? $clog2(DIV4) : 1;
    logic [CW-1:0] cnt;
    assign tick = en && cnt == CW'(DIV4 - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            qtr <= '0;
        end else if (!en) begin
            cnt <= '0;
            qtr <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) qtr <= qtr + 1'b1;
        end
    end
endmodule

// File: rtl/i2c_dri.sv
// i2c_dri: byte-level I2C/SCCB master running one register read or write per i2c_exec
module i2c_dri
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C,
    parameter int         CLK_FREQ   = 50_000_000,
    parameter int         I2C_FREQ   = 250_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i2c_exec,
    input  logic        bit_ctrl,
    input  logic        i2c_rh_wl,
    input  logic [15:0] i2c_addr,
    input  logic [7:0]  i2c_data_w,
    output logic [7:0]  i2c_data_r,
    output logic        i2c_done,
    output logic        i2c_ack,
    output logic        busy,
    output logic        scl,
    output logic        sda_o,
    output logic        sda_oe,
    input  logic        sda_i
);
    state_t      state, state_nxt;
    logic        tick, accept, bit_end, sample, byte_end, is_tx;
    logic [1:0]  qtr;
    logic [3:0]  bit_cnt;
    logic [7:0]  sh, tx_byte, data_w_q;
    logic [15:0] addr_q;
    logic        bit16_q, rd_q;

    i2c_qtick #(.DIV4(calc_div4(CLK_FREQ, I2C_FREQ))) u_qtick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state != ST_IDLE),
        .tick (tick),
        .qtr  (qtr)
    );

    // done is checked so an exec in the done cycle is not taken
    assign accept   = state == ST_IDLE && i2c_exec && !i2c_done;
    assign sample   = tick && qtr == 2'd2;
    assign bit_end  = tick && qtr == 2'd3;
    assign byte_end = bit_end && bit_cnt == 4'(BYTE_BITS - 1);
    assign busy     = state != ST_IDLE;
    assign sda_o    = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        is_tx     = state inside {ST_SLADDR_W, ST_ADDR_H, ST_ADDR_L, ST_DATA_WR, ST_SLADDR_R};
        tx_byte   = state == ST_SLADDR_W ? {SLAVE_ADDR, 1'b0} :
                    state == ST_SLADDR_R ? {SLAVE_ADDR, 1'b1} :
                    state == ST_ADDR_H   ? addr_q[15:8] :
                    state == ST_ADDR_L   ? addr_q[7:0] : data_w_q;
        // STOP keeps SCL high through its last quarter so the bus idles cleanly
        scl       = state == ST_IDLE || qtr == 2'd1 || qtr == 2'd2 || (state == ST_STOP && qtr == 2'd3);
        sda_oe    = state inside {ST_START, ST_RESTART} ? qtr[1] :
                    state == ST_STOP ? !qtr[1] :
                    is_tx && !bit_cnt[3] && !tx_byte[~bit_cnt[2:0]];
        case (state)
            ST_IDLE:     state_nxt = accept   ? ST_START : state;
            ST_START:    state_nxt = bit_end  ? ST_SLADDR_W : state;
            ST_SLADDR_W: state_nxt = byte_end ? (bit16_q ? ST_ADDR_H : ST_ADDR_L) : state;
            ST_ADDR_H:   state_nxt = byte_end ? ST_ADDR_L : state;
            ST_ADDR_L:   state_nxt = byte_end ? (rd_q ? ST_RESTART : ST_DATA_WR) : state;
            ST_DATA_WR:  state_nxt = byte_end ? ST_STOP : state;
            ST_RESTART:  state_nxt = bit_end  ? ST_SLADDR_R : state;
            ST_SLADDR_R: state_nxt = byte_end ? ST_DATA_RD : state;
            ST_DATA_RD:  state_nxt = byte_end ? ST_STOP : state;
            ST_STOP:     state_nxt = bit_end  ? ST_IDLE : state;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i2c_done   <= 1'b0;
            i2c_ack    <= 1'b0;
            i2c_data_r <= 8'h00;
            bit_cnt    <= 4'd0;
            sh         <= 8'h00;
            addr_q     <= 16'h0000;
            data_w_q   <= 8'h00;
            bit16_q    <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            i2c_done <= state == ST_STOP && bit_end;
            if (accept) begin
                addr_q   <= i2c_addr;
                data_w_q <= i2c_data_w;
                bit16_q  <= bit_ctrl;
                rd_q     <= i2c_rh_wl;
                i2c_ack  <= 1'b0;
            end
            if (bit_end)
                bit_cnt <= (is_tx || state == ST_DATA_RD) && !byte_end ? bit_cnt + 4'd1 : 4'd0;
            if (sample && is_tx && bit_cnt[3] && sda_i) i2c_ack <= 1'b1;
            if (sample && state == ST_DATA_RD && !bit_cnt[3]) sh <= {sh[6:0], sda_i};
            if (byte_end && state == ST_DATA_RD) i2c_data_r <= sh;
        end
    end
endmodule

// File: tb/tb_i2c_dri.sv
// tb_i2c_dri: scoreboard bench with a bus-level slave model decoding START/STOP/bytes
module tb_i2c_dri;
    typedef struct {
        string nm;
        int    v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, i2c_exec, bit_ctrl, i2c_rh_wl;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_data_w, i2c_data_r;
    logic        i2c_done, i2c_ack, busy, scl, sda_o, sda_oe;
    logic        sda_line;
    logic        slv_low = 1'b0;

    exp_t q[$];
    int   n_pass = 0, n_total = 0, tmo = 0;
    int   probe_seq = 0, probe_seen = 0;
    bit   end_req = 0, end_ack = 0;
    int   nack_pos = -1;
    logic [7:0] rd_val = 8'h00;

    always #10 clk = ~clk;

    assign sda_line = !(sda_oe && !sda_o) && !slv_low;

    i2c_dri dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i2c_exec  (i2c_exec),
        .bit_ctrl  (bit_ctrl),
        .i2c_rh_wl (i2c_rh_wl),
        .i2c_addr  (i2c_addr),
        .i2c_data_w(i2c_data_w),
        .i2c_data_r(i2c_data_r),
        .i2c_done  (i2c_done),
        .i2c_ack   (i2c_ack),
        .busy      (busy),
        .scl       (scl),
        .sda_o     (sda_o),
        .sda_oe    (sda_oe),
        .sda_i     (sda_line)
    );

    task automatic push(input string nm, input int v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        q.push_back(e);
    endtask

    task automatic probe(input int s, input int oe, input int b, input int d, input int a, input int r);
        push("scl", s); push("sda_oe", oe); push("sda_o", 0); push("busy", b);
        push("done", d); push("ack", a); push("rdata", r);
        probe_seq++;
    endtask

    task automatic exp_done(input int lat, input int a, input int r);
        push("stop", 0); push("lat", lat); push("ack", a); push("busy", 0); push("rdata", r);
    endtask

    task automatic issue(input logic bc, input logic rh, input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bit_ctrl = bc; i2c_rh_wl = rh; i2c_addr = a; i2c_data_w = d; i2c_exec = 1'b1;
        @(posedge clk); #1;
        i2c_exec = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 12000 && !seen; i++) begin
            @(negedge clk);
            seen = i2c_done;
        end
        if (!seen) tmo++;
        repeat (3) @(posedge clk);
    endtask

    // Monitor and slave model: the only process that compares or touches the counters
    initial begin : monitor
        int   cyc = 0, t0 = 0, cnt = 0, pos = 0;
        bit   active = 0, reading = 0;
        logic pscl = 1'b1, psda = 1'b1, sda_now;
        logic [7:0] shift = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            sda_now = sda_line;
            if (!rst_n) begin
                active = 0; reading = 0; cnt = 0; pos = 0; slv_low = 1'b0;
            end else begin
                if (i2c_exec && !busy && !i2c_done) t0 = cyc;
                if (scl && pscl && psda && !sda_now) begin
                    obs("start", pos);
                    active = 1; cnt = 0; pos = 0; reading = 0;
                end else if (scl && pscl && !psda && sda_now) begin
                    obs("stop", 0);
                    active = 0; pos = 0;
                end else if (active && scl && !pscl) begin
                    if (cnt < 8) shift = {shift[6:0], sda_now};
                    else if (reading) obs("mack", int'(sda_now));
                    cnt++;
                end else if (active && !scl && pscl) begin
                    if (cnt == 8) begin
                        if (!reading) obs("byte", int'(shift));
                        slv_low = !reading && pos != nack_pos;
                    end else if (cnt == 9) begin
                        cnt = 0;
                        if (pos == 0 && shift[0]) begin
                            reading = 1;
                            slv_low = !rd_val[7];
                        end else begin
                            reading = 0;
                            slv_low = 1'b0;
                        end
                        pos++;
                    end else if (cnt > 0) begin
                        slv_low = reading && !rd_val[3'(7 - cnt)];
                    end
                end
                // latency counted in edges from the accepting edge to the edge raising done
                if (i2c_done) begin
                    obs("lat", cyc - t0 - 1); obs("ack", int'(i2c_ack));
                    obs("busy", int'(busy)); obs("rdata", int'(i2c_data_r));
                end
            end
            if (probe_seq != probe_seen) begin
                obs("scl", int'(scl)); obs("sda_oe", int'(sda_oe)); obs("sda_o", int'(sda_o));
                obs("busy", int'(busy)); obs("done", int'(i2c_done)); obs("ack", int'(i2c_ack));
                obs("rdata", int'(i2c_data_r));
                probe_seen = probe_seq;
            end
            if (end_req && !end_ack) begin
                cmpv("leftover", q.size(), 0);
                cmpv("timeouts", tmo, 0);
                end_ack = 1;
            end
            pscl = scl;
            psda = sda_now;
        end
    end

    task automatic obs(input string nm, input int v);
        exp_t e;
        n_total++;
        if (q.size() == 0) begin
            $display("FAIL unexpected %s: got %0d, nothing expected", nm, v);
        end else begin
            e = q.pop_front();
            if (e.nm == nm && e.v == v) n_pass++;
            else $display("FAIL %s: got %s=%0h, expected %s=%0h", e.nm, nm, v, e.nm, e.v);
        end
    endtask

    task automatic cmpv(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    initial begin
        rst_n = 1'b0; i2c_exec = 1'b0; bit_ctrl = 1'b0; i2c_rh_wl = 1'b0;
        i2c_addr = 16'h0000; i2c_data_w = 8'h00;
        @(posedge clk); #1;
        probe(1, 0, 0, 0, 0, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        issue(1'b1, 1'b0, 16'h3103, 8'h11);
        push("start", 0); push("byte", 8'h78); push("byte", 8'h31); push("byte", 8'h03); push("byte", 8'h11);
        exp_done(7600, 0, 8'h00);
        wait_done();

        rd_val = 8'h56;
        issue(1'b1, 1'b1, 16'h300A, 8'h00);
        push("start", 0); push("byte", 8'h78); push("byte", 8'h30); push("byte", 8'h0A);
        push("start", 3); push("byte", 8'h79); push("mack", 1);
        exp_done(9600, 0, 8'h56);
        wait_done();

        nack_pos = 1;
        issue(1'b1, 1'b0, 16'h3103, 8'h11);
        push("start", 0); push("byte", 8'h78); push("byte", 8'h31); push("byte", 8'h03); push("byte", 8'h11);
        exp_done(7600, 1, 8'h56);
        wait_done();
        nack_pos = -1;

        issue(1'b0, 1'b0, 16'h0012, 8'hA5);
        probe(0, 0, 1, 0, 0, 8'h56);
        push("start", 0); push("byte", 8'h78); push("byte", 8'h12); push("byte", 8'hA5);
        exp_done(5800, 0, 8'h56);
        wait_done();

        rd_val = 8'hC3;
        issue(1'b0, 1'b1, 16'h000B, 8'h00);
        push("start", 0); push("byte", 8'h78); push("byte", 8'h0B);
        push("start", 2); push("byte", 8'h79); push("mack", 1);
        exp_done(7800, 0, 8'hC3);
        wait_done();

        issue(1'b1, 1'b0, 16'h4000, 8'h5A);
        push("start", 0); push("byte", 8'h78); push("byte", 8'h40); push("byte", 8'h00); push("byte", 8'h5A);
        exp_done(7600, 0, 8'hC3);
        repeat (98) @(posedge clk);
        #1;
        bit_ctrl = 1'b0; i2c_rh_wl = 1'b1; i2c_addr = 16'hFFFF; i2c_data_w = 8'hFF; i2c_exec = 1'b1;
        @(posedge clk); #1;
        i2c_exec = 1'b0;
        wait_done();

        issue(1'b1, 1'b0, 16'h3103, 8'h11);
        push("start", 0); push("byte", 8'h78); push("byte", 8'h31);
        repeat (4599) @(posedge clk);
        #1 rst_n = 1'b0;
        probe(1, 0, 0, 0, 0, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        issue(1'b1, 1'b0, 16'h3108, 8'h42);
        push("start", 0); push("byte", 8'h78); push("byte", 8'h31); push("byte", 8'h08); push("byte", 8'h42);
        exp_done(7600, 0, 8'h00);
        wait_done();

        end_req = 1;
        for (int i = 0; i < 10 && !end_ack; i++) @(negedge clk);
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
